// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for pong: idle/serve/play/miss/over FSM, BCD score, lives and
// high score, plus the ball motion enable and recentre pulse for the pixel generator.
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       ball_reset,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [7:0] hi_score
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [5:0] SERVE_CNT  = 6'(SERVE_FRAMES);
  localparam logic [5:0] MISS_CNT   = 6'(MISS_FRAMES);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] score_d, score_inc, hi_d;
  logic [1:0] lives_d;
  logic       start_q, start_rise;
  logic       run_d, brst_d;

  assign start_rise = start & ~start_q;
  assign state      = state_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      score      <= 8'h00;
      lives      <= 2'd0;
      hi_score   <= 8'h00;
      start_q    <= 1'b0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score      <= score_d;
      lives      <= lives_d;
      hi_score   <= hi_d;
      start_q    <= start;
      ball_run   <= run_d;
      ball_reset <= brst_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start_rise) state_d = S_SERVE;
      S_SERVE:        if (frame_tick && cnt_q == 6'd1) state_d = S_PLAY;
      S_PLAY:         if (miss) state_d = S_MISS;
      S_MISS:
        if (frame_tick && cnt_q == 6'd1)
          state_d = (lives == 2'd0) ? S_OVER : S_SERVE;
      default:        state_d = S_IDLE;
    endcase
  end

  // BCD increment saturating at 99.
  always_comb begin
    if (score == 8'h99)
      score_inc = score;
    else if (score[3:0] == 4'd9)
      score_inc = {score[7:4] + 4'd1, 4'd0};
    else
      score_inc = {score[7:4], score[3:0] + 4'd1};
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d   = cnt_q;
    score_d = score;
    lives_d = lives;
    hi_d    = hi_score;
    case (state_q)
      S_IDLE, S_OVER:
        if (start_rise) begin
          score_d = 8'h00;
          lives_d = LIVES_INIT;
          cnt_d   = SERVE_CNT;
        end
      S_SERVE:
        if (frame_tick && cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
      S_PLAY:
        if (miss) begin
          lives_d = lives - 2'd1;
          cnt_d   = MISS_CNT;
        end else if (hit) begin
          score_d = score_inc;
        end
      S_MISS:
        if (frame_tick) begin
          if (state_d == S_SERVE)   cnt_d = SERVE_CNT;
          else if (cnt_q != 6'd0)   cnt_d = cnt_q - 6'd1;
        end
      default: ;
    endcase
    // BCD digits order the same way as binary, so a plain compare works.
    if (state_d == S_OVER && state_q != S_OVER && score > hi_score)
      hi_d = score;
    run_d  = (state_d == S_PLAY);
    brst_d = (state_d == S_SERVE) && (state_q != S_SERVE);
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed game scenarios plus random play, each cycle
// compared against an integer-score game model.
module tb_pong_game_ctrl;

  localparam int L  = 3;
  localparam int SF = 2;
  localparam int MF = 1;
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_MISS = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [2:0] state;
  logic       ball_run, ball_reset;
  logic [7:0] score, hi_score;
  logic [1:0] lives;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl #(.LIVES(L), .SERVE_FRAMES(SF), .MISS_FRAMES(MF)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .hit(hit), .miss(miss), .state(state), .ball_run(ball_run),
    .ball_reset(ball_reset), .score(score), .lives(lives), .hi_score(hi_score)
  );

  always #5 clk = ~clk;

  // Game model: score and high score kept as plain integers 0..99.
  int m_state, m_score, m_lives, m_hi, m_cnt, m_prev;
  bit m_start_q, m_run, m_brst, m_rise;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = P_IDLE; m_score = 0; m_lives = 0; m_hi = 0; m_cnt = 0;
      m_start_q = 0; m_run = 0; m_brst = 0;
    end else begin
      m_rise = start && !m_start_q;
      m_start_q = start;
      m_prev = m_state;
      case (m_state)
        P_IDLE, P_OVER:
          if (m_rise) begin m_state = P_SERVE; m_score = 0; m_lives = L; m_cnt = SF; end
        P_SERVE:
          if (frame_tick) begin
            if (m_cnt == 1) m_state = P_PLAY;
            if (m_cnt > 0) m_cnt--;
          end
        P_PLAY:
          if (miss) begin m_lives--; m_cnt = MF; m_state = P_MISS; end
          else if (hit && m_score < 99) m_score++;
        P_MISS:
          if (frame_tick) begin
            if (m_cnt == 1) begin
              if (m_lives == 0) begin
                m_state = P_OVER;
                if (m_score > m_hi) m_hi = m_score;
              end else begin
                m_state = P_SERVE; m_cnt = SF;
              end
            end else if (m_cnt > 0) m_cnt--;
          end
        default: m_state = P_IDLE;
      endcase
      m_run  = (m_state == P_PLAY);
      m_brst = (m_state == P_SERVE) && (m_prev != P_SERVE);
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [22:0] model_vec();
    return {3'(m_state), m_run, m_brst, to_bcd(m_score), 2'(m_lives), to_bcd(m_hi)};
  endfunction

  wire [22:0] dut_vec = {state, ball_run, ball_reset, score, lives, hi_score};

  // Driver: one clock with the given pulses, returning at the following negedge.
  task automatic cycle(input logic f, input logic h, input logic m);
    frame_tick = f; hit = h; miss = m;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic to_play();
    start = 1'b1; cycle(0, 0, 0); start = 1'b0;
    repeat (SF) cycle(1, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 23'd0) begin
      errors++; $display("FAIL reset_values dut=%h exp=%h", dut_vec, 23'd0);
    end
    reset = 1'b0;
    cycle(0, 1, 1);
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL idle_ignore dut=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  task automatic test_start();
    int n_br = 0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      if (ball_reset) n_br++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL start_cyc%0d dut=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    start = 1'b0;
    checks++;
    if (n_br != 1 || state !== 3'd1 || lives !== 2'd3 || score !== 8'h00) begin
      errors++;
      $display("FAIL start_entry br_count=%0d state=%0d lives=%0d score=%h exp 1/1/3/00",
               n_br, state, lives, score);
    end
  endtask

  task automatic test_serve();
    for (int k = 0; k < SF; k++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL serve_gap dut=%h exp=%h", dut_vec, model_vec());
        end
      end
      cycle(1, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL serve_tick%0d dut=%h exp=%h", k, dut_vec, model_vec());
      end
    end
    checks++;
    if (state !== 3'd2 || ball_run !== 1'b1) begin
      errors++; $display("FAIL play_entry state=%0d ball_run=%b exp 2/1", state, ball_run);
    end
  endtask

  task automatic test_score();
    for (int i = 0; i < 12; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        start = 1'($urandom_range(0, 1));
        cycle(1'($urandom_range(0, 1)), 0, 0);
      end
      cycle(0, 1, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL hit%0d dut=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    start = 1'b0;
    checks++;
    if (score !== 8'h12) begin
      errors++; $display("FAIL score_12 got=%h exp=12", score);
    end
    repeat (87) cycle(0, 1, 0);
    checks++;
    if (score !== 8'h99 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL score_99 got=%h exp=99", score);
    end
    cycle(0, 1, 0);
    checks++;
    if (score !== 8'h99) begin
      errors++; $display("FAIL score_sat got=%h exp=99", score);
    end
  endtask

  task automatic test_game_over();
    for (int n = 0; n < L; n++) begin
      cycle(0, 0, 1);
      checks++;
      if (state !== 3'd3 || lives !== 2'(L - 1 - n)) begin
        errors++; $display("FAIL miss%0d state=%0d lives=%0d exp 3/%0d", n, state, lives, L - 1 - n);
      end
      cycle(1, 0, 0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL miss_exit%0d dut=%h exp=%h", n, dut_vec, model_vec());
      end
      if (n < L - 1) repeat (SF) cycle(1, 0, 0);
    end
    checks++;
    if (state !== 3'd4 || ball_run !== 1'b0 || hi_score !== 8'h99) begin
      errors++; $display("FAIL game_over state=%0d run=%b hi=%h exp 4/0/99", state, ball_run, hi_score);
    end
  endtask

  task automatic test_hit_miss_same();
    to_play();
    repeat (5) cycle(0, 1, 0);
    cycle(0, 1, 1);
    checks++;
    if (state !== 3'd3 || score !== 8'h05 || lives !== 2'd2) begin
      errors++; $display("FAIL hit_miss state=%0d score=%h lives=%0d exp 3/05/2", state, score, lives);
    end
    cycle(1, 0, 0);
    repeat (SF) cycle(1, 0, 0);
    cycle(0, 0, 1); cycle(1, 0, 0);
    repeat (SF) cycle(1, 0, 0);
    cycle(0, 0, 1); cycle(1, 0, 0);
    checks++;
    if (state !== 3'd4 || hi_score !== 8'h99 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL hi_keep state=%0d hi=%h exp 4/99", state, hi_score);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 15) == 0));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL random_cyc%0d dut=%h exp=%h", i, dut_vec, model_vec());
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    cycle(0, 0, 0);
    to_play();
    repeat (7) cycle(0, 1, 0);
    checks++;
    if (state !== 3'd2 || score !== 8'h07) begin
      errors++; $display("FAIL pre_reset state=%0d score=%h exp 2/07", state, score);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 23'd0) begin
      errors++; $display("FAIL async_reset dut=%h exp=%h", dut_vec, 23'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      cycle(1, 1, 0);
      checks++;
      if (dut_vec !== 23'd0) begin
        errors++; $display("FAIL reset_hold%0d dut=%h exp=%h", i, dut_vec, 23'd0);
      end
    end
    start = 1'b0; reset = 1'b0;
    cycle(0, 0, 0);
    checks++;
    if (dut_vec !== model_vec() || state !== 3'd0) begin
      errors++; $display("FAIL post_reset dut=%h exp=%h", dut_vec, model_vec());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start();
    test_serve();
    test_score();
    test_game_over();
    test_hit_miss_same();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
